// File: rtl/uart_param.sv
// Parametrised single-clock UART with TX/RX FIFOs, optional parity, 1 or 2 stop bits
// and sticky RX error reporting. Baud timing is a clk_main divider; no derived clocks.
module uart_param #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_HZ     = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_LOG2   = 4
) (
  input  logic                 clk_main,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  input  logic                 err_clear,
  output logic [FIFO_LOG2:0]   tx_level,
  output logic [FIFO_LOG2:0]   rx_level,
  output logic                 uart_tx,
  input  logic                 uart_rx
);

  localparam int DIV   = CLK_FREQ_HZ / BAUD_HZ;
  localparam int CW    = $clog2(DIV) + 1;
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam logic [CW-1:0]      BIT_END  = CW'(DIV - 1);
  localparam logic [CW-1:0]      HALF_END = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0]      STOP_END = CW'(STOP_BITS * DIV - 1);
  localparam logic [FIFO_LOG2:0] FULL     = (FIFO_LOG2 + 1)'(DEPTH);
  localparam logic [3:0]         LAST_BIT = 4'(DATA_BITS - 1);

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    if (PARITY == 2) begin
      return ~(^d);
    end else begin
      return ^d;
    end
  endfunction

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_WAIT_HIGH} rx_state_e;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [DEPTH];
  logic [FIFO_LOG2-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [FIFO_LOG2:0]   tx_cnt_q, tx_cnt_d;
  logic                 tx_push, tx_pop, tx_empty;
  logic [DATA_BITS-1:0] tx_head;

  assign tx_ready = (tx_cnt_q != FULL);
  assign tx_push  = tx_valid & tx_ready;
  assign tx_empty = (tx_cnt_q == {(FIFO_LOG2 + 1){1'b0}});
  assign tx_head  = tx_mem[tx_rp_q];
  assign tx_level = tx_cnt_q;

  always_comb begin
    tx_wp_d = tx_push ? tx_wp_q + FIFO_LOG2'(1) : tx_wp_q;
    tx_rp_d = tx_pop  ? tx_rp_q + FIFO_LOG2'(1) : tx_rp_q;
    if (tx_push && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + (FIFO_LOG2 + 1)'(1);
    end else if (!tx_push && tx_pop) begin
      tx_cnt_d = tx_cnt_q - (FIFO_LOG2 + 1)'(1);
    end else begin
      tx_cnt_d = tx_cnt_q;
    end
  end

  always_ff @(posedge clk_main) begin
    if (tx_push) begin
      tx_mem[tx_wp_q] <= tx_data;
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_baud_q, tx_baud_d;
  logic [3:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sr_q, tx_sr_d;
  logic                 tx_par_q, tx_par_d;
  logic                 uart_tx_q, uart_tx_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = tx_baud_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_sr_d    = tx_sr_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_baud_d = CW'(0);
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_sr_d    = tx_head;
          tx_par_d   = par_bit(tx_head);
          tx_state_d = TX_START;
        end else begin
          tx_state_d = TX_IDLE;
        end
      end
      TX_START: begin
        if (tx_baud_q == BIT_END) begin
          tx_baud_d  = CW'(0);
          tx_bit_d   = 4'd0;
          tx_state_d = TX_DATA;
        end else begin
          tx_state_d = TX_START;
        end
      end
      TX_DATA: begin
        if (tx_baud_q == BIT_END) begin
          tx_baud_d = CW'(0);
          tx_sr_d   = {1'b0, tx_sr_q[DATA_BITS-1:1]};
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = (PARITY != 0) ? TX_PAR : TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
          end
        end else begin
          tx_state_d = TX_DATA;
        end
      end
      TX_PAR: begin
        if (tx_baud_q == BIT_END) begin
          tx_baud_d  = CW'(0);
          tx_state_d = TX_STOP;
        end else begin
          tx_state_d = TX_PAR;
        end
      end
      TX_STOP: begin
        if (tx_baud_q == STOP_END) begin
          tx_baud_d = CW'(0);
          // Chain straight into the next start bit so back-to-back frames have no gap
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_sr_d    = tx_head;
            tx_par_d   = par_bit(tx_head);
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_state_d = TX_STOP;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_baud_d  = CW'(0);
      end
    endcase
  end

  always_comb begin
    case (tx_state_q)
      TX_IDLE:  uart_tx_d = 1'b1;
      TX_START: uart_tx_d = 1'b0;
      TX_DATA:  uart_tx_d = tx_sr_q[0];
      TX_PAR:   uart_tx_d = tx_par_q;
      TX_STOP:  uart_tx_d = 1'b1;
      default:  uart_tx_d = 1'b1;
    endcase
  end

  assign uart_tx = uart_tx_q;
  assign tx_busy = (tx_state_q != TX_IDLE) | ~tx_empty;

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp_q    <= {FIFO_LOG2{1'b0}};
      tx_rp_q    <= {FIFO_LOG2{1'b0}};
      tx_cnt_q   <= {(FIFO_LOG2 + 1){1'b0}};
      tx_state_q <= TX_IDLE;
      tx_baud_q  <= CW'(0);
      tx_bit_q   <= 4'd0;
      tx_sr_q    <= {DATA_BITS{1'b0}};
      tx_par_q   <= 1'b0;
      uart_tx_q  <= 1'b1;
    end else begin
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_sr_q    <= tx_sr_d;
      tx_par_q   <= tx_par_d;
      uart_tx_q  <= uart_tx_d;
    end
  end

  // ---------------- RX synchroniser, FSM and FIFO ----------------
  logic                 rx_meta_q, rx_sync_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_baud_q, rx_baud_d;
  logic [3:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sr_q, rx_sr_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d, rx_ovr_q, rx_ovr_d;
  logic                 ferr_set, ovr_set, rx_push, rx_pop;
  logic [DATA_BITS:0]   rx_mem [DEPTH];
  logic [DATA_BITS:0]   rx_head;
  logic [FIFO_LOG2-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [FIFO_LOG2:0]   rx_cnt_q, rx_cnt_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sr_d    = rx_sr_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    ovr_set    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        rx_baud_d = CW'(0);
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
        end else begin
          rx_state_d = RX_IDLE;
        end
      end
      RX_START: begin
        if (rx_baud_q == HALF_END) begin
          rx_baud_d = CW'(0);
          rx_bit_d  = 4'd0;
          rx_perr_d = 1'b0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_state_d = RX_START;
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BIT_END) begin
          rx_baud_d = CW'(0);
          rx_sr_d   = {rx_sync_q, rx_sr_q[DATA_BITS-1:1]};
          if (rx_bit_q == LAST_BIT) begin
            rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 4'd1;
          end
        end else begin
          rx_state_d = RX_DATA;
        end
      end
      RX_PAR: begin
        if (rx_baud_q == BIT_END) begin
          rx_baud_d  = CW'(0);
          rx_perr_d  = (rx_sync_q != par_bit(rx_sr_q));
          rx_state_d = RX_STOP;
        end else begin
          rx_state_d = RX_PAR;
        end
      end
      RX_STOP: begin
        // Back to IDLE at mid-stop so the next start edge is never missed
        if (rx_baud_q == BIT_END) begin
          rx_baud_d = CW'(0);
          if (rx_sync_q) begin
            rx_state_d = RX_IDLE;
            if (rx_cnt_q != FULL) begin
              rx_push = 1'b1;
            end else begin
              ovr_set = 1'b1;
            end
          end else begin
            ferr_set   = 1'b1;
            rx_state_d = RX_WAIT_HIGH;
          end
        end else begin
          rx_state_d = RX_STOP;
        end
      end
      RX_WAIT_HIGH: begin
        rx_baud_d  = CW'(0);
        rx_state_d = rx_sync_q ? RX_IDLE : RX_WAIT_HIGH;
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_baud_d  = CW'(0);
      end
    endcase
  end

  always_comb begin
    if (ferr_set) begin
      rx_ferr_d = 1'b1;
    end else if (err_clear) begin
      rx_ferr_d = 1'b0;
    end else begin
      rx_ferr_d = rx_ferr_q;
    end
    if (ovr_set) begin
      rx_ovr_d = 1'b1;
    end else if (err_clear) begin
      rx_ovr_d = 1'b0;
    end else begin
      rx_ovr_d = rx_ovr_q;
    end
  end

  assign rx_pop  = rx_ack & (rx_cnt_q != {(FIFO_LOG2 + 1){1'b0}});
  assign rx_head = rx_mem[rx_rp_q];

  always_comb begin
    rx_wp_d = rx_push ? rx_wp_q + FIFO_LOG2'(1) : rx_wp_q;
    rx_rp_d = rx_pop  ? rx_rp_q + FIFO_LOG2'(1) : rx_rp_q;
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + (FIFO_LOG2 + 1)'(1);
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - (FIFO_LOG2 + 1)'(1);
    end else begin
      rx_cnt_d = rx_cnt_q;
    end
  end

  always_ff @(posedge clk_main) begin
    if (rx_push) begin
      rx_mem[rx_wp_q] <= {rx_perr_q, rx_sr_q};
    end
  end

  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= CW'(0);
      rx_bit_q   <= 4'd0;
      rx_sr_q    <= {DATA_BITS{1'b0}};
      rx_perr_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_wp_q    <= {FIFO_LOG2{1'b0}};
      rx_rp_q    <= {FIFO_LOG2{1'b0}};
      rx_cnt_q   <= {(FIFO_LOG2 + 1){1'b0}};
    end else begin
      rx_meta_q  <= uart_rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_sr_q    <= rx_sr_d;
      rx_perr_q  <= rx_perr_d;
      rx_ferr_q  <= rx_ferr_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

  assign rx_data       = rx_head[DATA_BITS-1:0];
  assign rx_parity_err = rx_head[DATA_BITS];
  assign rx_valid      = (rx_cnt_q != {(FIFO_LOG2 + 1){1'b0}});
  assign rx_level      = rx_cnt_q;
  assign rx_frame_err  = rx_ferr_q;
  assign rx_overrun    = rx_ovr_q;

endmodule

// File: tb/tb_uart_param.sv
// Bench for uart_param: three instances (no/even/odd parity) at DIV=12, each TX looped
// to its RX unless the bench drives the line itself; frames are checked against a bit model.
module tb_uart_param;
  localparam int DIV = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2:0][7:0] tx_data, rx_data;
  logic [2:0]      tx_valid, tx_ready, tx_busy, rx_parity_err, rx_valid, rx_ack;
  logic [2:0]      rx_frame_err, rx_overrun, err_clear, uart_tx, uart_rx;
  logic [2:0][4:0] tx_level, rx_level;
  logic [2:0]      ext_en, ext_line;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign uart_rx[g] = ext_en[g] ? ext_line[g] : uart_tx[g];
    uart_param #(.CLK_FREQ_HZ(12000000), .BAUD_HZ(1000000), .DATA_BITS(8),
                 .PARITY(g), .STOP_BITS(1), .FIFO_LOG2(4)) u_dut (
      .clk_main(clk), .rst_n(rst_n), .tx_data(tx_data[g]), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .tx_busy(tx_busy[g]), .rx_data(rx_data[g]),
      .rx_parity_err(rx_parity_err[g]), .rx_valid(rx_valid[g]), .rx_ack(rx_ack[g]),
      .rx_frame_err(rx_frame_err[g]), .rx_overrun(rx_overrun[g]), .err_clear(err_clear[g]),
      .tx_level(tx_level[g]), .rx_level(rx_level[g]), .uart_tx(uart_tx[g]), .uart_rx(uart_rx[g])
    );
  end

  int cyc = 0;
  logic [2:0] txl [16384];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < 16384) txl[cyc] <= uart_tx;

  int total = 0;
  int bad = 0;
  bit auto_ack = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] txq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Expected line level of bit slot 'pos' of a frame carrying b on instance idx
  function automatic logic bit_of(input int idx, input logic [7:0] b, input int pos);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9 && idx != 0) return (idx == 1) ? ones[0] : ~ones[0];
    return 1'b1;
  endfunction

  // Advance to the next falling edge; DUT0's RX is drained against exp_q when auto_ack is on
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    if (auto_ack) begin
      if (rx_valid[0]) begin
        if (exp_q.size() != 0) e = {23'd0, exp_q.pop_front()};
        else e = 32'h0000DEAD;
        chk("rx0_entry", {23'd0, rx_parity_err[0], rx_data[0]}, e);
        rx_ack[0] = 1'b1;
      end else begin
        rx_ack[0] = 1'b0;
      end
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) step();
  endtask

  task automatic send(input int idx, input logic [7:0] b, output int start);
    chk("tx_ready_pre", {31'd0, tx_ready[idx]}, 32'd1);
    tx_data[idx] = b;
    tx_valid[idx] = 1'b1;
    start = cyc + 3;
    step();
    tx_valid[idx] = 1'b0;
  endtask

  task automatic check_frames(input string tag, input int idx, input int start, input int n);
    int fl, mism;
    logic [7:0] b;
    fl = (idx == 0) ? 10 * DIV : 11 * DIV;
    wait_cyc(start + n * fl + 2);
    mism = 0;
    if (txl[start-1][idx] !== 1'b1) mism++;
    for (int f = 0; f < n; f++) begin
      b = txq.pop_front();
      for (int k = 0; k < fl; k++)
        if (txl[start + f * fl + k][idx] !== bit_of(idx, b, k / DIV)) mism++;
    end
    if (txl[start + n * fl][idx] !== 1'b1) mism++;
    chk(tag, mism, 32'd0);
  endtask

  task automatic inject(input int idx, input logic [7:0] b, input logic flip, input logic stopv);
    int nb;
    logic v;
    nb = (idx == 0) ? 10 : 11;
    for (int p = 0; p < nb; p++) begin
      v = bit_of(idx, b, p);
      if (p == nb - 1) v = stopv;
      else if (p == 9) v = v ^ flip;
      ext_line[idx] = v;
      repeat (DIV) step();
    end
    ext_line[idx] = 1'b1;
    repeat (DIV) step();
  endtask

  initial begin
    int s, acc;
    logic [7:0] b;
    rst_n = 1'b0;
    tx_data = '0; tx_valid = 3'b000; rx_ack = 3'b000; err_clear = 3'b000;
    ext_en = 3'b000; ext_line = 3'b111;
    repeat (3) @(negedge clk);
    chk("rst_uart_tx", {29'd0, uart_tx}, 32'd7);
    chk("rst_tx_ready", {29'd0, tx_ready}, 32'd7);
    chk("rst_rx_valid", {29'd0, rx_valid}, 32'd0);
    chk("rst_tx_level", tx_level[0], 32'd0);
    chk("rst_rx_level", rx_level[0], 32'd0);
    chk("rst_busy", {29'd0, tx_busy}, 32'd0);
    chk("rst_flags", {30'd0, rx_frame_err[0], rx_overrun[0]}, 32'd0);
    rst_n = 1'b1;
    repeat (3) step();
    auto_ack = 1'b1;

    // 8N1 loopback of 0xA5, then random bytes
    exp_q.push_back(9'h0A5); txq.push_back(8'hA5);
    send(0, 8'hA5, s);
    check_frames("tx_a5_frame", 0, s, 1);
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back({1'b0, b}); txq.push_back(b);
      send(0, b, s);
      check_frames("tx_rand_frame", 0, s, 1);
    end
    repeat (5) step();
    chk("rx0_drain_a", exp_q.size(), 32'd0);

    // Even (idx 1) and odd (idx 2) parity: loopback then an injected bad-parity frame
    for (int idx = 1; idx < 3; idx++) begin
      for (int k = 0; k < 2; k++) begin
        b = (k == 0) ? 8'h07 : 8'($urandom_range(0, 255));
        txq.push_back(b);
        send(idx, b, s);
        check_frames("tx_par_frame", idx, s, 1);
        repeat (3) step();
        chk("par_rx_valid", {31'd0, rx_valid[idx]}, 32'd1);
        chk("par_rx_entry", {23'd0, rx_parity_err[idx], rx_data[idx]}, {24'd0, b});
        rx_ack[idx] = 1'b1; step(); rx_ack[idx] = 1'b0;
      end
      if (idx == 1) chk("even_par_bit_07", {31'd0, bit_of(1, 8'h07, 9)}, 32'd1);
      else chk("odd_par_bit_07", {31'd0, bit_of(2, 8'h07, 9)}, 32'd0);
      ext_en[idx] = 1'b1;
      b = 8'($urandom_range(0, 255));
      inject(idx, b, 1'b1, 1'b1);
      chk("perr_rx_valid", {31'd0, rx_valid[idx]}, 32'd1);
      chk("perr_entry", {23'd0, rx_parity_err[idx], rx_data[idx]}, {23'd0, 1'b1, b});
      rx_ack[idx] = 1'b1; step(); rx_ack[idx] = 1'b0;
      step();
      chk("perr_rx_level", rx_level[idx], 32'd0);
      ext_en[idx] = 1'b0;
    end

    // Burst: push every cycle until full, then expect 17 back-to-back frames
    acc = 0; s = 0;
    for (int i = 0; i < 40; i++) begin
      if (!tx_ready[0]) break;
      b = 8'($urandom_range(0, 255));
      tx_data[0] = b; tx_valid[0] = 1'b1;
      if (acc == 0) s = cyc + 3;
      acc++;
      txq.push_back(b); exp_q.push_back({1'b0, b});
      step();
    end
    tx_valid[0] = 1'b0;
    chk("burst_accepted", acc, 32'd17);
    chk("burst_tx_level", tx_level[0], 32'd16);
    chk("burst_tx_ready", {31'd0, tx_ready[0]}, 32'd0);
    wait_cyc(s + 17 * 10 * DIV - 4);
    chk("burst_busy_last", {31'd0, tx_busy[0]}, 32'd1);
    check_frames("burst_frames", 0, s, 17);
    chk("burst_busy_done", {31'd0, tx_busy[0]}, 32'd0);
    repeat (20) step();
    chk("rx0_drain_burst", exp_q.size(), 32'd0);

    // Framing error, sticky hold, clear, then clean frame
    ext_en[0] = 1'b1;
    inject(0, 8'h3C, 1'b0, 1'b0);
    repeat (10) step();
    chk("ferr_set", {31'd0, rx_frame_err[0]}, 32'd1);
    chk("ferr_no_entry", rx_level[0], 32'd0);
    repeat (30) step();
    chk("ferr_hold", {31'd0, rx_frame_err[0]}, 32'd1);
    err_clear[0] = 1'b1; step(); err_clear[0] = 1'b0; step();
    chk("ferr_cleared", {31'd0, rx_frame_err[0]}, 32'd0);
    exp_q.push_back(9'h05A);
    inject(0, 8'h5A, 1'b0, 1'b1);
    repeat (5) step();
    chk("rx0_drain_5a", exp_q.size(), 32'd0);

    // Short low glitch must be rejected
    ext_line[0] = 1'b0;
    repeat (3) step();
    ext_line[0] = 1'b1;
    repeat (30) step();
    chk("glitch_level", rx_level[0], 32'd0);
    chk("glitch_flags", {30'd0, rx_frame_err[0], rx_overrun[0]}, 32'd0);
    b = 8'($urandom_range(0, 255));
    exp_q.push_back({1'b0, b});
    inject(0, b, 1'b0, 1'b1);
    repeat (5) step();
    chk("rx0_drain_glitch", exp_q.size(), 32'd0);

    // Overrun: 17 frames, no ack
    auto_ack = 1'b0; rx_ack[0] = 1'b0;
    for (int i = 0; i < 17; i++) inject(0, 8'(i), 1'b0, 1'b1);
    chk("ovr_level", rx_level[0], 32'd16);
    chk("ovr_flag", {31'd0, rx_overrun[0]}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("ovr_pop_order", {24'd0, rx_data[0]}, i);
      rx_ack[0] = 1'b1; step();
    end
    rx_ack[0] = 1'b0;
    step();
    chk("ovr_empty", rx_level[0], 32'd0);
    chk("ovr_sticky", {31'd0, rx_overrun[0]}, 32'd1);

    // Reset in the middle of a frame
    ext_en[0] = 1'b0;
    send(0, 8'h00, s);
    wait_cyc(s + 40);
    chk("pre_rst_low", {31'd0, uart_tx[0]}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_uart_tx", {31'd0, uart_tx[0]}, 32'd1);
    chk("rst_mid_levels", {22'd0, tx_level[0], rx_level[0]}, 32'd0);
    chk("rst_mid_flags", {30'd0, rx_frame_err[0], rx_overrun[0]}, 32'd0);
    chk("rst_mid_busy", {31'd0, tx_busy[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    chk("post_rst_idle", {31'd0, uart_tx[0]}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
